// File: rtl/wvb_overflow_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : wvb_overflow_ctrl_mc
// Brief    : Multi-channel waveform buffer overflow controller. Tracks each
//            channel's read pointer from the header stop address and reports
//            overflow, occupancy, almost-full (with hysteresis), a sticky
//            overflow flag and a saturating overflow-entry counter.
//            Optional feature macro: WVB_OVF_PEAK_EN adds a per-channel
//            peak-occupancy output (wused_peak).
// Revision : 1.0 - initial release
// ============================================================================
module wvb_overflow_ctrl_mc #(
    parameter int P_N_CHAN    = 24,
    parameter int P_ADR_WIDTH = 12,
    parameter int P_HYST      = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] wvb_wr_addr,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] stop_addr,
    input  logic [P_N_CHAN-1:0]             wvb_rddone,
    input  logic [P_N_CHAN-1:0]             hdr_full,
    input  logic [15:0]                     afull_thresh,
    input  logic                            ovf_clr,
    output logic [P_N_CHAN-1:0]             overflow,
    output logic [P_N_CHAN*16-1:0]          wvb_wused,
    output logic [P_N_CHAN-1:0]             almost_full,
    output logic [P_N_CHAN-1:0]             ovf_sticky,
    output logic [P_N_CHAN*16-1:0]          ovf_cnt
`ifdef WVB_OVF_PEAK_EN
    ,
    output logic [P_N_CHAN*16-1:0]          wused_peak
`endif
);

    localparam logic [16:0] c_HYST    = 17'(P_HYST);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    for (genvar gi = 0; gi < P_N_CHAN; gi++) begin : g_chan
        logic [P_ADR_WIDTH-1:0] w_wr;
        logic [P_ADR_WIDTH-1:0] w_stop;
        logic [P_ADR_WIDTH-1:0] w_next_rd;
        logic [P_ADR_WIDTH-1:0] w_diff;
        logic [16:0]            w_wused_hyst;
        logic                   w_af_set;
        logic                   w_af_clr;
        logic                   w_ovf;
        logic                   w_entry;
        logic [P_ADR_WIDTH-1:0] r_last_rd;
        logic [15:0]            r_wused;
        logic                   r_afull;
        logic                   r_ovf_d;
        logic                   r_sticky;
        logic [15:0]            r_ovf_cnt;

        assign w_wr         = wvb_wr_addr[gi*P_ADR_WIDTH +: P_ADR_WIDTH];
        assign w_stop       = stop_addr[gi*P_ADR_WIDTH +: P_ADR_WIDTH];
        // Modulo arithmetic: the buffer is circular, so wrap is intended.
        assign w_next_rd    = r_last_rd + 1'b1;
        assign w_diff       = w_wr - w_next_rd;
        // Hysteresis sum kept at 17 bits so a large wused cannot wrap below the threshold.
        assign w_wused_hyst = {1'b0, r_wused} + c_HYST;
        assign w_af_set     = (r_wused >= afull_thresh);
        assign w_af_clr     = (w_wused_hyst < {1'b0, afull_thresh});
        assign w_ovf        = hdr_full[gi] | (w_wr == r_last_rd);
        assign w_entry      = w_ovf & ~r_ovf_d;

        assign overflow[gi]           = w_ovf;
        assign wvb_wused[gi*16 +: 16] = r_wused;
        assign almost_full[gi]        = r_afull;
        assign ovf_sticky[gi]         = r_sticky;
        assign ovf_cnt[gi*16 +: 16]   = r_ovf_cnt;

        // Read pointer: last address consumed, taken from the head event's stop address.
        always_ff @(posedge clk) begin
            if (rst)                  r_last_rd <= '1;
            else if (wvb_rddone[gi])  r_last_rd <= w_stop;
        end

        // Occupancy, computed against the pre-edge read pointer.
        always_ff @(posedge clk) begin
            if (rst) r_wused <= '0;
            else     r_wused <= 16'(w_diff);
        end

        // Almost-full with hysteresis, driven from the registered occupancy.
        always_ff @(posedge clk) begin
            if (rst)           r_afull <= 1'b0;
            else if (w_af_set) r_afull <= 1'b1;
            else if (w_af_clr) r_afull <= 1'b0;
        end

        // Delayed overflow used to detect overflow entry.
        always_ff @(posedge clk) begin
            if (rst) r_ovf_d <= 1'b0;
            else     r_ovf_d <= w_ovf;
        end

        // Sticky flag: a live overflow beats a simultaneous clear.
        always_ff @(posedge clk) begin
            if (rst)          r_sticky <= 1'b0;
            else if (w_ovf)   r_sticky <= 1'b1;
            else if (ovf_clr) r_sticky <= 1'b0;
        end

        // Saturating entry counter; a clear coinciding with an entry counts that entry.
        always_ff @(posedge clk) begin
            if (rst)                                 r_ovf_cnt <= '0;
            else if (ovf_clr)                        r_ovf_cnt <= {15'd0, w_entry};
            else if (w_entry && r_ovf_cnt != c_CNT_MAX) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end

`ifdef WVB_OVF_PEAK_EN
        logic [15:0] r_peak;

        assign wused_peak[gi*16 +: 16] = r_peak;

        // Peak occupancy since last clear; clearing restarts from the current occupancy.
        always_ff @(posedge clk) begin
            if (rst)                    r_peak <= '0;
            else if (ovf_clr)           r_peak <= r_wused;
            else if (r_wused > r_peak)  r_peak <= r_wused;
        end
`else
        // Peak tracking not built in this configuration.
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_wvb_overflow_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_wvb_overflow_ctrl_mc
// Brief    : Self-checking bench for wvb_overflow_ctrl_mc (4 channels,
//            12-bit addresses, hysteresis 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wvb_overflow_ctrl_mc;

    localparam int NC = 4;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*AW-1:0]  wvb_wr_addr;
    logic [NC*AW-1:0]  stop_addr;
    logic [NC-1:0]     wvb_rddone;
    logic [NC-1:0]     hdr_full;
    logic [15:0]       afull_thresh;
    logic              ovf_clr;
    logic [NC-1:0]     overflow;
    logic [NC*16-1:0]  wvb_wused;
    logic [NC-1:0]     almost_full;
    logic [NC-1:0]     ovf_sticky;
    logic [NC*16-1:0]  ovf_cnt;

    int checks   = 0;
    int failures = 0;

    wvb_overflow_ctrl_mc #(
        .P_N_CHAN    (NC),
        .P_ADR_WIDTH (AW),
        .P_HYST      (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wvb_wr_addr  (wvb_wr_addr),
        .stop_addr    (stop_addr),
        .wvb_rddone   (wvb_rddone),
        .hdr_full     (hdr_full),
        .afull_thresh (afull_thresh),
        .ovf_clr      (ovf_clr),
        .overflow     (overflow),
        .wvb_wused    (wvb_wused),
        .almost_full  (almost_full),
        .ovf_sticky   (ovf_sticky),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [11:0] wr;
        logic [11:0] stop;
        logic        rd;
        logic        hf;
        logic [15:0] thr;
        logic        clr;
        logic        e_ovf;
        logic [15:0] e_wused;
        logic        e_af;
        logic        e_st;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        //        ch  wr      stop    rd    hf    thr       clr   ovf   wused     af    st    cnt
        tbl[0]  = '{0, 12'h010, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1, 12'h000, 12'h0FF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1, 12'h050, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0F50, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{2, 12'h100, 12'h123, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{2, 12'h122, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0FFE, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{2, 12'h123, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b1, 16'd1};
        tbl[6]  = '{2, 12'h123, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0FFF, 1'b0, 1'b1, 16'd1};
        tbl[7]  = '{3, 12'h7FF, 12'h000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'h07FF, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{3, 12'h800, 12'h000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{3, 12'h7C1, 12'h000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'h07C1, 1'b1, 1'b0, 16'd0};
        tbl[10] = '{3, 12'h7BF, 12'h000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'h07BF, 1'b1, 1'b0, 16'd0};
        tbl[11] = '{3, 12'h7BF, 12'h000, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0, 16'h07BF, 1'b0, 1'b0, 16'd0};
        tbl[12] = '{3, 12'h7BF, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h07BF, 1'b1, 1'b0, 16'd0};
        tbl[13] = '{3, 12'h7BF, 12'h000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h07BF, 1'b0, 1'b0, 16'd0};

        rst          = 1'b1;
        wvb_wr_addr  = '0;
        stop_addr    = '0;
        wvb_rddone   = '0;
        hdr_full     = '0;
        afull_thresh = 16'hFFFF;
        ovf_clr      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_wused",   64'(wvb_wused),   64'd0);
        check("reset_afull",   64'(almost_full), 64'd0);
        check("reset_sticky",  64'(ovf_sticky),  64'd0);
        check("reset_cnt",     64'(ovf_cnt),     64'd0);
        check("reset_ovf",     64'(overflow),    64'd0);

        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-channel vectors
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            wvb_rddone                           = '0;
            wvb_rddone[tbl[i].ch]                = tbl[i].rd;
            hdr_full[tbl[i].ch]                  = tbl[i].hf;
            wvb_wr_addr[tbl[i].ch*AW +: AW]      = tbl[i].wr;
            stop_addr[tbl[i].ch*AW +: AW]        = tbl[i].stop;
            afull_thresh                         = tbl[i].thr;
            ovf_clr                              = tbl[i].clr;
            #1;
            check($sformatf("v%0d_ovf", i), 64'(overflow[tbl[i].ch]), 64'(tbl[i].e_ovf));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wused", i),  64'(wvb_wused[tbl[i].ch*16 +: 16]), 64'(tbl[i].e_wused));
            check($sformatf("v%0d_afull", i),  64'(almost_full[tbl[i].ch]),        64'(tbl[i].e_af));
            check($sformatf("v%0d_sticky", i), 64'(ovf_sticky[tbl[i].ch]),         64'(tbl[i].e_st));
            check($sformatf("v%0d_cnt", i),    64'(ovf_cnt[tbl[i].ch*16 +: 16]),   64'(tbl[i].e_cnt));
        end

        // Holding overflow on ch2 must not re-count
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wvb_rddone = '0;
            #1;
            check("hold_ovf2", 64'(overflow[2]), 64'd1);
            @(posedge clk);
            #1;
            check("hold_cnt2", 64'(ovf_cnt[2*16 +: 16]), 64'd1);
        end

        // Saturation on ch0: counter preloaded to max on an entry cycle
        @(negedge clk);
        force dut.g_chan[0].r_ovf_cnt = 16'hFFFF;
        hdr_full[0] = 1'b1;
        @(posedge clk);
        #1;
        release dut.g_chan[0].r_ovf_cnt;
        #1;
        check("sat_cnt0_a", 64'(ovf_cnt[15:0]), 64'hFFFF);
        check("sat_sticky0", 64'(ovf_sticky[0]), 64'd1);
        @(negedge clk);
        hdr_full[0] = 1'b0;
        @(negedge clk);
        hdr_full[0] = 1'b1;
        @(posedge clk);
        #1;
        check("sat_cnt0_b", 64'(ovf_cnt[15:0]), 64'hFFFF);

        // Clear coinciding with an entry
        @(negedge clk);
        hdr_full[0] = 1'b0;
        @(negedge clk);
        hdr_full[0] = 1'b1;
        ovf_clr     = 1'b1;
        @(posedge clk);
        #1;
        check("clr_entry_cnt0",    64'(ovf_cnt[15:0]), 64'd1);
        check("clr_entry_sticky0", 64'(ovf_sticky[0]), 64'd1);
        // Clear with overflow held (no entry): count 0, sticky still set
        @(negedge clk);
        @(posedge clk);
        #1;
        check("clr_hold_cnt0",    64'(ovf_cnt[15:0]), 64'd0);
        check("clr_hold_sticky0", 64'(ovf_sticky[0]), 64'd1);
        // Clear with no overflow: sticky drops
        @(negedge clk);
        hdr_full[0] = 1'b0;
        @(posedge clk);
        #1;
        check("clr_idle_sticky0", 64'(ovf_sticky[0]), 64'd0);
        @(negedge clk);
        ovf_clr = 1'b0;

        // Reset mid-operation, with rddone asserted during reset
        @(negedge clk);
        check("pre_rst_nonzero", 64'(wvb_wused != '0), 64'd1);
        rst         = 1'b1;
        wvb_rddone  = '1;
        stop_addr   = {NC{12'h100}};
        wvb_wr_addr = {NC{12'h010}};
        ovf_clr     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wused",  64'(wvb_wused),   64'd0);
        check("rst_afull",  64'(almost_full), 64'd0);
        check("rst_sticky", 64'(ovf_sticky),  64'd0);
        check("rst_cnt",    64'(ovf_cnt),     64'd0);
        check("rst_ovf",    64'(overflow),    64'd0);
        @(negedge clk);
        rst            = 1'b0;
        wvb_rddone     = '0;
        ovf_clr        = 1'b0;
        wvb_wr_addr[0 +: AW] = 12'hFFF;
        #1;
        check("post_rst_ovf", 64'(overflow), 64'b0001);
        @(posedge clk);
        #1;
        check("post_rst_wused0", 64'(wvb_wused[15:0]),  64'h0FFF);
        check("post_rst_wused1", 64'(wvb_wused[31:16]), 64'h0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
